// File: rtl/bind_ss_pkg.sv
// Shared types and constants for the segmented-shift bind/unbind engine.
package bind_ss_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN
   } fsm_state;

   localparam logic BIND   = 1'b0;
   localparam logic UNBIND = 1'b1;

   function automatic int seg_idx_w(input int length_segment);
      return $clog2(length_segment);
   endfunction

endpackage

// File: rtl/ss_lane.sv
// One lane: lowest-set-bit index of B drives a cyclic rotate of A
// (left for bind, right for unbind). Purely combinational.
module ss_lane
   import bind_ss_pkg::*;
#(
   parameter int LENGTH_SEGMENT = 32
) (
   input  logic [LENGTH_SEGMENT-1:0] i_seg_a,
   input  logic [LENGTH_SEGMENT-1:0] i_seg_b,
   input  logic                      i_mode,
   output logic [LENGTH_SEGMENT-1:0] o_seg_out
);

   localparam int IW = seg_idx_w(LENGTH_SEGMENT);

   logic [IW-1:0]             w_idx;
   logic [IW:0]               w_inv;
   logic [LENGTH_SEGMENT-1:0] w_rotl;
   logic [LENGTH_SEGMENT-1:0] w_rotr;

   // Scan from the top so the lowest set bit is the last to write; all-zero leaves 0.
   always_comb begin
      w_idx = '0;
      for (int i = LENGTH_SEGMENT - 1; i >= 0; i--) begin
         if (i_seg_b[i]) begin
            w_idx = IW'(i);
         end
      end
   end

   // A shift by the full width yields zero, so idx = 0 reduces to a pass-through.
   assign w_inv  = (IW+1)'(LENGTH_SEGMENT) - {1'b0, w_idx};
   assign w_rotl = (i_seg_a << w_idx) | (i_seg_a >> w_inv);
   assign w_rotr = (i_seg_a >> w_idx) | (i_seg_a << w_inv);

   assign o_seg_out = (i_mode == UNBIND) ? w_rotr : w_rotl;

endmodule

// File: rtl/bind_ss_multilane.sv
// Multi-lane segmented-shift bind/unbind engine with one output register stage.
// Optional sticky one-hot checker on B enabled by BIND_SS_ONEHOT_CHECK_EN.
module bind_ss_multilane
   import bind_ss_pkg::*;
#(
   parameter int D              = 1024,
   parameter int LENGTH_SEGMENT = 32,
   parameter int NB_LANES       = 4
) (
   input  logic                               clk,
   input  logic                               arst_n_in,
   input  logic                               start,
   input  logic                               mode_unbind,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NB_LANES*LENGTH_SEGMENT-1:0] seg_a,
   input  logic [NB_LANES*LENGTH_SEGMENT-1:0] seg_b,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NB_LANES*LENGTH_SEGMENT-1:0] seg_out,
   output logic                               out_last,
   output logic                               done,
   output logic                               busy
`ifdef BIND_SS_ONEHOT_CHECK_EN
   ,
   output logic                               err_onehot
`endif
);

   localparam int NB_OF_SEGMENTS = D / LENGTH_SEGMENT;
   localparam int NB_BEATS       = NB_OF_SEGMENTS / NB_LANES;
   localparam int W              = NB_LANES * LENGTH_SEGMENT;
   localparam int CW             = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(NB_BEATS - 1);

   fsm_state      r_state;
   logic [CW-1:0] r_beat_cnt;
   logic          r_mode;
   logic          r_out_valid;
   logic          r_out_last;
   logic          r_done;
   logic [W-1:0]  r_seg_out;
   logic [W-1:0]  w_lane_out;
   logic          w_accept;
   logic          w_out_hs;

   for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
      ss_lane #(
         .LENGTH_SEGMENT (LENGTH_SEGMENT)
      ) u_lane (
         .i_seg_a   (seg_a[gi*LENGTH_SEGMENT +: LENGTH_SEGMENT]),
         .i_seg_b   (seg_b[gi*LENGTH_SEGMENT +: LENGTH_SEGMENT]),
         .i_mode    (r_mode),
         .o_seg_out (w_lane_out[gi*LENGTH_SEGMENT +: LENGTH_SEGMENT])
      );
   end

   assign in_ready  = (r_state == RUN) && (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_out_hs  = r_out_valid && out_ready;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign seg_out   = r_seg_out;
   assign done      = r_done;
   assign busy      = (r_state != IDLE);

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_state     <= IDLE;
         r_beat_cnt  <= '0;
         r_mode      <= BIND;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_seg_out   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // A new beat may replace the held one in the same cycle it drains.
         if (w_accept) begin
            r_seg_out   <= w_lane_out;
            r_out_last  <= (r_beat_cnt == LAST_BEAT);
            r_out_valid <= 1'b1;
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mode     <= mode_unbind;
                  r_beat_cnt <= '0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               if (w_accept) begin
                  if (r_beat_cnt == LAST_BEAT) begin
                     r_beat_cnt <= '0;
                     r_state    <= DRAIN;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_out_hs && r_out_last) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef BIND_SS_ONEHOT_CHECK_EN
   logic [NB_LANES-1:0] w_bad;
   logic                r_err_onehot;

   // Not one-hot: empty, or clearing the lowest set bit leaves something behind.
   for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_chk
      logic [LENGTH_SEGMENT-1:0] w_b;
      assign w_b       = seg_b[gi*LENGTH_SEGMENT +: LENGTH_SEGMENT];
      assign w_bad[gi] = (w_b == '0) || ((w_b & (w_b - 1'b1)) != '0);
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_err_onehot <= 1'b0;
      end else if ((r_state == IDLE) && start) begin
         r_err_onehot <= 1'b0;
      end else if (w_accept && (|w_bad)) begin
         r_err_onehot <= 1'b1;
      end
   end

   assign err_onehot = r_err_onehot;
`endif

endmodule

// File: doc/bind_ss_multilane.md
Name: bind_ss_multilane

Overview:
- Parametrised segmented-shift bind/unbind engine for sparse segmented binary hypervectors.
- Processes NB_LANES segments per beat over a valid/ready stream and counts beats to frame one full hypervector.
- Each lane cyclically rotates its segment of A by the index of the active bit in the matching segment of B: left rotation for bind, right rotation for unbind.
- Sits between the hypervector register bank and downstream bundling/similarity logic.

Parameters:
- D, 1024, hypervector dimension in bits.
- LENGTH_SEGMENT, 32, bits per segment; power of two, at least 2.
- NB_LANES, 4, segments processed per beat; NB_OF_SEGMENTS must be divisible by NB_LANES.
- NB_OF_SEGMENTS (localparam), D/LENGTH_SEGMENT, segments per hypervector.
- NB_BEATS (localparam), NB_OF_SEGMENTS/NB_LANES, beats per hypervector.

Ports:
- clk  in  1  clock, rising edge.
- arst_n_in  in  1  asynchronous active-low reset.
- start  in  1  begin a new hypervector; sampled only in IDLE.
- mode_unbind  in  1  0 = bind (rotate left), 1 = unbind (rotate right); latched on start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- seg_a  in  NB_LANES*LENGTH_SEGMENT  A segments; lane i occupies bits [i*LENGTH_SEGMENT +: LENGTH_SEGMENT].
- seg_b  in  NB_LANES*LENGTH_SEGMENT  B segments, same packing as seg_a.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- seg_out  out  NB_LANES*LENGTH_SEGMENT  result segments.
- out_last  out  1  marks the final beat of the hypervector.
- done  out  1  one-cycle pulse after the last output handshake.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset, asynchronous: state = IDLE, beat_cnt = 0, mode = 0. All outputs are 0: in_ready, out_valid, seg_out, out_last, done, busy.
- Reset mid-operation aborts the current hypervector. No done pulse is produced and partial output is discarded.
- Lane function:
  - idx = index of the lowest set bit of the B segment.
  - Bind: out = rotl(A, idx). Unbind: out = rotr(A, idx).
  - Rotation is modulo LENGTH_SEGMENT.
  - B segment all-zero: idx = 0, so A passes through unchanged.
  - Multiple set bits in B: the lowest index wins.
- Pipeline and handshake:
  - One output register stage. An accepted beat appears on seg_out the next cycle with out_valid = 1.
  - in_ready = (state == RUN) && (!out_valid || out_ready), giving full throughput of 1 beat/cycle.
  - While out_valid && !out_ready, seg_out and out_last hold stable and in_ready = 0.
  - out_valid drops after a handshake unless a new beat is accepted in the same cycle.
- States:
  - IDLE: on start, latch mode_unbind, clear beat_cnt, go to RUN. Without start, stay in IDLE.
  - RUN: on each accepted beat, beat_cnt increments. out_last is registered as (beat_cnt == NB_BEATS-1). After accepting the beat with beat_cnt == NB_BEATS-1, go to DRAIN and wrap beat_cnt to 0.
  - DRAIN: in_ready = 0. On out_valid && out_ready && out_last, pulse done for one cycle and go to IDLE.
- start asserted outside IDLE is ignored. start together with in_valid in the IDLE cycle accepts no beat, because in_ready is 0 in IDLE.
- NB_BEATS = 1 is supported: the single beat carries out_last = 1.

Optional Feature:
- Macro: BIND_SS_ONEHOT_CHECK_EN.
- Defined:
  - Adds output err_onehot (1 bit, reset 0).
  - Set sticky when an accepted B segment is not exactly one-hot, i.e. zero bits or more than one bit set.
  - Cleared on start.
  - Datapath result is unchanged.
- Undefined: no port, no checker logic.

Decomposition:
- Package bind_ss_pkg: fsm_state enum (IDLE, RUN, DRAIN), mode constants BIND = 0 and UNBIND = 1, and a segment-index width function $clog2(LENGTH_SEGMENT).
- One sub-module, ss_lane: combinational priority encoder plus bidirectional barrel rotate, parameter LENGTH_SEGMENT.
- The top instantiates NB_LANES ss_lane instances via generate and owns the FSM, counter and output register.

Test Plan:
- Bind, LENGTH_SEGMENT = 32, lane 0: A = bit 3, B = bit 5 -> seg_out lane 0 = bit 8, one cycle after the handshake.
- Wrap-around: bind A = bit 30, B = bit 5 -> bit 3. Unbind A = bit 2, B = bit 5 -> bit 29. Unbind A = bit 8, B = bit 5 -> bit 3.
- Full vector, D = 1024, NB_LANES = 4, continuous valid/ready -> 8 output beats on consecutive cycles, out_last only on the 8th, done pulse 1 cycle after the 8th handshake, busy low the following cycle.
- Backpressure: out_ready held low 3 cycles mid-stream -> seg_out stable, in_ready = 0 throughout, no beat lost or duplicated. Output order matches input order.
- B segment all-zero -> output equals A. B = bits {4, 9} -> rotation by 4. With BIND_SS_ONEHOT_CHECK_EN, err_onehot rises and stays high until the next start.
- arst_n_in pulled low after beat 3 of 8 -> all outputs 0 immediately. A new start afterwards runs a clean 8-beat vector with out_last on beat 8.
